// File: rtl/fpga_boot_seq_pkg.sv
// Shared types and constants for the FPGA boot sequencer.
package fpga_boot_seq_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fpga_boot_seq_state_e;

   // Exit code reported when the RUN-state watchdog fires.
   localparam logic [31:0] EXIT_TIMEOUT_CODE = 32'hFFFF_FFFF;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpga_btn_debounce.sv
// Reset push-button conditioning: 2-flop synchroniser, polarity correction
// and a consecutive-cycle debounce counter. btn_db is 1 while pressed.
module fpga_btn_debounce
   import fpga_boot_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
   input  logic clk_gen,
   input  logic rst_n,
   input  logic btn,
   output logic btn_db
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync_meta_reg;
   logic            sync_reg;
   logic            pressed;
   logic [DB_W-1:0] db_cnt_reg;
   logic            btn_db_reg;

   // Polarity is applied after synchronisation so the sync flops reset to 0.
   assign pressed = BTN_ACTIVE_HIGH ? sync_reg : ~sync_reg;

   // Synchronise the raw pin and only accept a change after it persists.
   always_ff @(posedge clk_gen) begin
      if (!rst_n) begin
         sync_meta_reg <= 1'b0;
         sync_reg      <= 1'b0;
         db_cnt_reg    <= '0;
         btn_db_reg    <= 1'b0;
      end else begin
         sync_meta_reg <= btn;
         sync_reg      <= sync_meta_reg;
         if (pressed != btn_db_reg) begin
            if (db_cnt_reg == DB_LAST) begin
               btn_db_reg <= pressed;
               db_cnt_reg <= '0;
            end else begin
               db_cnt_reg <= db_cnt_reg + 1'b1;
            end
         end else begin
            db_cnt_reg <= '0;
         end
      end
   end

   assign btn_db = btn_db_reg;

endmodule

// File: rtl/fpga_boot_sequencer.sv
// Board-level reset/boot sequencer for x_heep_system. Holds the system in
// reset until the clock wizard is locked and the button is released for
// HOLD_CYCLES, latches the boot straps at release, captures the exit status
// and drives the status LED.
// Optional RUN-state watchdog: define FPGA_BOOT_SEQ_WDT_EN.
module fpga_boot_sequencer
   import fpga_boot_seq_pkg::*;
#(
   parameter int HOLD_CYCLES     = 16,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LED_DIV         = 27,
   parameter bit BTN_ACTIVE_HIGH = 1'b1,
   parameter int WDT_CYCLES      = 2**30
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        btn_i,
   input  logic        pll_locked_i,
   input  logic        boot_select_raw_i,
   input  logic        exec_flash_raw_i,
   input  logic        exit_valid_i,
   input  logic [31:0] exit_value_i,
   output logic        sys_rst_no,
   output logic        boot_select_o,
   output logic        execute_from_flash_o,
   output logic [31:0] exit_code_o,
   output logic        done_o,
   output logic        timeout_o,
   output logic        status_led_o
);

   localparam int HOLD_W = cnt_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   // Bit 0: pll_locked, bit 1: boot_select strap, bit 2: exec_flash strap.
   logic [2:0] raw_vec;
   logic [2:0] sync_meta_reg;
   logic [2:0] sync_reg;
   logic       locked_s;
   logic       boot_sel_s;
   logic       exec_flash_s;
   logic       btn_db;
   logic       ok;
   logic       wdt_expired;

   fpga_boot_seq_state_e state_reg, state_next;
   logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;
   logic                 sys_rst_n_reg, sys_rst_n_next;
   logic                 boot_sel_reg, boot_sel_next;
   logic                 exec_flash_reg, exec_flash_next;
   logic [31:0]          exit_code_reg, exit_code_next;
   logic                 done_reg, done_next;
   logic                 timeout_reg, timeout_next;
   logic [LED_DIV-1:0]   led_cnt_reg;
   logic                 led;

   assign raw_vec = {exec_flash_raw_i, boot_select_raw_i, pll_locked_i};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         // Two-flop synchroniser for each asynchronous level input.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               sync_meta_reg[gi] <= 1'b0;
               sync_reg[gi]      <= 1'b0;
            end else begin
               sync_meta_reg[gi] <= raw_vec[gi];
               sync_reg[gi]      <= sync_meta_reg[gi];
            end
         end
      end
   endgenerate

   assign locked_s     = sync_reg[0];
   assign boot_sel_s   = sync_reg[1];
   assign exec_flash_s = sync_reg[2];

   fpga_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_HIGH (BTN_ACTIVE_HIGH)
   ) u_btn_debounce (
      .clk_gen (clk_i),
      .rst_n   (rst_ni),
      .btn     (btn_i),
      .btn_db  (btn_db)
   );

   assign ok = locked_s & ~btn_db;

`ifdef FPGA_BOOT_SEQ_WDT_EN
   localparam int WDT_W = cnt_width(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_cnt_reg;

   // Count RUN cycles; any other state parks the counter at zero for the next entry.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || state_reg != RUN) begin
         wdt_cnt_reg <= '0;
      end else begin
         wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
      end
   end

   assign wdt_expired = (state_reg == RUN) && (wdt_cnt_reg == WDT_LAST);
`else
   // WDT_CYCLES has no role without the watchdog; timeout_reg is never set.
   logic wdt_cfg_unused;
   assign wdt_cfg_unused = |WDT_CYCLES;
   assign wdt_expired    = 1'b0;
`endif

   // Next-state and registered-output logic; HOLD always wins over an exit or a timeout.
   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = '0;
      sys_rst_n_next  = sys_rst_n_reg;
      boot_sel_next   = boot_sel_reg;
      exec_flash_next = exec_flash_reg;
      exit_code_next  = exit_code_reg;
      done_next       = done_reg;
      timeout_next    = timeout_reg;
      case (state_reg)
         HOLD: begin
            sys_rst_n_next = 1'b0;
            exit_code_next = '0;
            done_next      = 1'b0;
            timeout_next   = 1'b0;
            if (ok) begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_next      = RUN;
                  sys_rst_n_next  = 1'b1;
                  boot_sel_next   = boot_sel_s;
                  exec_flash_next = exec_flash_s;
               end else begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end
            end
         end
         RUN: begin
            if (!ok) begin
               state_next     = HOLD;
               sys_rst_n_next = 1'b0;
               exit_code_next = '0;
               done_next      = 1'b0;
               timeout_next   = 1'b0;
            end else if (exit_valid_i) begin
               state_next     = DONE;
               exit_code_next = exit_value_i;
               done_next      = 1'b1;
            end else if (wdt_expired) begin
               state_next     = DONE;
               exit_code_next = EXIT_TIMEOUT_CODE;
               done_next      = 1'b1;
               timeout_next   = 1'b1;
            end
         end
         DONE: begin
            if (!ok) begin
               state_next     = HOLD;
               sys_rst_n_next = 1'b0;
               exit_code_next = '0;
               done_next      = 1'b0;
               timeout_next   = 1'b0;
            end
         end
         default: begin
            state_next     = HOLD;
            sys_rst_n_next = 1'b0;
            exit_code_next = '0;
            done_next      = 1'b0;
            timeout_next   = 1'b0;
         end
      endcase
   end

   // State register and all sequencer outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg      <= HOLD;
         hold_cnt_reg   <= '0;
         sys_rst_n_reg  <= 1'b0;
         boot_sel_reg   <= 1'b0;
         exec_flash_reg <= 1'b0;
         exit_code_reg  <= '0;
         done_reg       <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         sys_rst_n_reg  <= sys_rst_n_next;
         boot_sel_reg   <= boot_sel_next;
         exec_flash_reg <= exec_flash_next;
         exit_code_reg  <= exit_code_next;
         done_reg       <= done_next;
         timeout_reg    <= timeout_next;
      end
   end

   // Free-running blink divider; wraps silently.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         led_cnt_reg <= '0;
      end else begin
         led_cnt_reg <= led_cnt_reg + 1'b1;
      end
   end

   // LED pattern: off in reset, slow blink running, solid on success, fast blink on error.
   always_comb begin
      led = 1'b0;
      case (state_reg)
         RUN:     led = led_cnt_reg[LED_DIV-1];
         DONE:    led = ((exit_code_reg != '0) || timeout_reg) ? led_cnt_reg[LED_DIV-3] : 1'b1;
         default: led = 1'b0;
      endcase
   end

   assign sys_rst_no           = sys_rst_n_reg;
   assign boot_select_o        = boot_sel_reg;
   assign execute_from_flash_o = exec_flash_reg;
   assign exit_code_o          = exit_code_reg;
   assign done_o               = done_reg;
   assign timeout_o            = timeout_reg;
   assign status_led_o         = led;

endmodule
